// File: rtl/dff_serial_rx_if.sv
// rtl/dff_serial_rx_if.sv - serial link and word-report bundle for the DFF error-count receiver
//
// Purpose: groups the asynchronous serial inputs (data_clk, data_in, start)
// with the reassembled-word report outputs of dff_serial_rx.
//
// Signals:
//   data_clk     serial shift clock, asynchronous to the system clock
//   data_in      serial data, sampled on data_clk rising edges
//   start        frame start request, acts on its rising edge
//   word_data    last completed word
//   word_index   index of word_data within the frame
//   word_valid   one-cycle pulse when word_data/word_index update
//   frame_done   one-cycle pulse with the last word of a frame
//   frame_error  sticky timeout flag, cleared by the next start
//   busy         high while a frame is being received
//
// Modports:
//   slave   receiver side (dff_serial_rx)
//   master  stream source / observer side
interface dff_serial_rx_if #(
  parameter int WORD_W = 32
) ();

  logic              data_clk;
  logic              data_in;
  logic              start;
  logic [WORD_W-1:0] word_data;
  logic [3:0]        word_index;
  logic              word_valid;
  logic              frame_done;
  logic              frame_error;
  logic              busy;

  modport slave (
    input  data_clk,
    input  data_in,
    input  start,
    output word_data,
    output word_index,
    output word_valid,
    output frame_done,
    output frame_error,
    output busy
  );

  modport master (
    output data_clk,
    output data_in,
    output start,
    input  word_data,
    input  word_index,
    input  word_valid,
    input  frame_done,
    input  frame_error,
    input  busy
  );

endinterface

// File: rtl/dff_serial_rx.sv
// rtl/dff_serial_rx.sv - deserializing receiver for the DFF error-count readout stream
//
// Purpose: brings the externally clocked shift clock, data and start lines
// into the CLK domain, reassembles WORD_W-bit words (word 0 first, MSB
// first) and reports each word and the end of each WORDS-word frame.
// A frame that stalls for TIMEOUT cycles is aborted with a sticky error.
//
// Ports:
//   CLK    system clock
//   reset  synchronous active-high reset
//   rx     dff_serial_rx_if.slave: data_clk/data_in/start in,
//          word_data/word_index/word_valid/frame_done/frame_error/busy out
//
// Timing: a pin edge on data_clk or start is acted on by the core state 3
// CLK later; every reported output is registered once more after that, so
// word_valid and busy move 4 CLK after the corresponding pin edge.
module dff_serial_rx #(
  parameter int WORDS   = 14,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 50000
) (
  input logic           CLK,
  input logic           reset,
  dff_serial_rx_if.slave rx
);

  localparam int BIT_W = $clog2(WORD_W);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [3:0]       LAST_WORD = 4'(WORDS - 1);
  // Fires on the cycle whose increment lands the counter on TIMEOUT-1, so
  // the registered frame_error/busy change exactly TIMEOUT cycles after
  // the last detected data_clk edge.
  localparam logic [15:0]      TMO_FIRE  = 16'(TIMEOUT - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchronizers (s1, s2) plus one edge-detect stage (s3)
  logic dclk_s1, dclk_s2, dclk_s3;
  logic din_s1, din_s2;
  logic start_s1, start_s2, start_s3;

  logic dclk_edge;
  logic start_edge;

  state_t            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              err_q, err_d;
  logic              wdone_q, wdone_d;
  logic              fdone_q, fdone_d;
  logic [3:0]        done_idx_q, done_idx_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      dclk_s1  <= 1'b0;
      dclk_s2  <= 1'b0;
      dclk_s3  <= 1'b0;
      din_s1   <= 1'b0;
      din_s2   <= 1'b0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
    end else begin
      dclk_s1  <= rx.data_clk;
      dclk_s2  <= dclk_s1;
      dclk_s3  <= dclk_s2;
      din_s1   <= rx.data_in;
      din_s2   <= din_s1;
      start_s1 <= rx.start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
    end
  end

  assign dclk_edge  = dclk_s2 & ~dclk_s3;
  assign start_edge = start_s2 & ~start_s3;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
      wdone_q    <= 1'b0;
      fdone_q    <= 1'b0;
      done_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      err_q      <= err_d;
      wdone_q    <= wdone_d;
      fdone_q    <= fdone_d;
      done_idx_q <= done_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    err_d      = err_q;
    wdone_d    = 1'b0;
    fdone_d    = 1'b0;
    done_idx_d = done_idx_q;

    case (state_q)
      IDLE: begin
        // data_clk edges are ignored until a frame is requested
        if (start_edge) begin
          state_d    = RECV;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tmo_d      = '0;
          shift_d    = '0;
          err_d      = 1'b0;
        end
      end

      RECV: begin
        // start has priority over a coincident data edge or timeout
        if (start_edge) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tmo_d      = '0;
          shift_d    = '0;
          err_d      = 1'b0;
        end else if (dclk_edge) begin
          shift_d = {shift_q[WORD_W-2:0], din_s2};
          tmo_d   = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            wdone_d    = 1'b1;
            done_idx_d = word_cnt_q;
            if (word_cnt_q == LAST_WORD) begin
              fdone_d = 1'b1;
              state_d = IDLE;
            end else begin
              word_cnt_d = word_cnt_q + 4'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_q == TMO_FIRE) begin
            // partial word is simply abandoned; a later start clears it
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output stage: the completed word is still intact in shift_q here,
  // since the next data edge is at least 6 CLK away.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rx.word_data   <= '0;
      rx.word_index  <= '0;
      rx.word_valid  <= 1'b0;
      rx.frame_done  <= 1'b0;
      rx.frame_error <= 1'b0;
      rx.busy        <= 1'b0;
    end else begin
      rx.word_valid  <= wdone_q;
      rx.frame_done  <= fdone_q;
      rx.frame_error <= err_q;
      rx.busy        <= (state_q == RECV);
      if (wdone_q) begin
        rx.word_data  <= shift_q;
        rx.word_index <= done_idx_q;
      end
    end
  end

endmodule

// File: tb/tb_dff_serial_rx.sv
// tb/tb_dff_serial_rx.sv - randomized self-checking bench for dff_serial_rx
module tb_dff_serial_rx;

  localparam int WORDS   = 14;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 2000;

  logic CLK = 1'b0;
  logic reset = 1'b1;

  dff_serial_rx_if #(.WORD_W(WORD_W)) bus ();

  dff_serial_rx #(
    .WORDS(WORDS),
    .WORD_W(WORD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .rx(bus)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]        idx;
    logic [WORD_W-1:0] data;
    logic              last;
    int unsigned       cyc;
  } exp_t;

  exp_t exp_q[$];

  // Frame model: which word/bit the stream is at, from the source's view
  bit                in_frame = 0;
  int                nbits = 0;
  int                widx = 0;
  logic [WORD_W-1:0] cur = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_edge(input logic b, input int unsigned c);
    exp_t e;
    if (in_frame) begin
      cur = {cur[WORD_W-2:0], b};
      nbits++;
      if (nbits == WORD_W) begin
        e.idx  = 4'(widx);
        e.data = cur;
        e.last = (widx == WORDS - 1);
        e.cyc  = c + 4;
        exp_q.push_back(e);
        nbits = 0;
        if (widx == WORDS - 1) in_frame = 0;
        else widx++;
      end
    end
  endtask

  // Called at a negedge; data_in changes with the falling data_clk and is
  // held lo cycles before and hi cycles after the rising edge.
  task automatic send_bit(input logic b, input int hi, input int lo);
    bus.data_clk = 1'b0;
    bus.data_in  = b;
    repeat (lo) @(negedge CLK);
    bus.data_clk = 1'b1;
    model_edge(b, cyc);
    repeat (hi) @(negedge CLK);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w, input int hi, input int lo);
    for (int i = WORD_W - 1; i >= 0; i--) send_bit(w[i], hi, lo);
  endtask

  task automatic send_random_bits(input int n);
    for (int i = 0; i < n; i++)
      send_bit(1'($urandom), $urandom_range(3, 6), $urandom_range(3, 6));
  endtask

  task automatic do_start(input bit check_idle_busy);
    int unsigned c;
    bus.start = 1'b1;
    c = cyc;
    in_frame = 1;
    nbits = 0;
    widx = 0;
    cur = '0;
    while (cyc < c + 3) @(negedge CLK);
    if (check_idle_busy) check("busy_before_start_seen", bus.busy, 0);
    @(negedge CLK);
    check("busy_4clk_after_start", bus.busy, 1);
    check("frame_error_cleared_by_start", bus.frame_error, 0);
    bus.start = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic drain();
    repeat (8) @(negedge CLK);
    check("words_outstanding", exp_q.size(), 0);
  endtask

  // Single compare process against the model's expected word stream
  initial begin
    exp_t e;
    bit prev_v;
    prev_v = 0;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        check("word_valid_back_to_back", prev_v & bus.word_valid, 0);
        if (bus.word_valid) begin
          check("word_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("word_index", bus.word_index, e.idx);
            check("word_data", bus.word_data, e.data);
            check("frame_done_with_word", bus.frame_done, e.last);
            check("word_valid_latency", cyc, e.cyc);
          end
        end else begin
          check("frame_done_without_word", bus.frame_done, 0);
        end
        prev_v = bus.word_valid;
      end else begin
        prev_v = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned c_last;
    int hi, lo, pre;
    logic [WORD_W-1:0] w;

    bus.data_clk = 1'b0;
    bus.data_in  = 1'b0;
    bus.start    = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("reset_word_data", bus.word_data, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_frame_error", bus.frame_error, 0);

    // Reset mid-frame, then stray edges, then a clean frame
    do_start(1);
    send_random_bits(50);
    reset = 1'b1;
    in_frame = 0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    check("midreset_word_data", bus.word_data, 0);
    check("midreset_word_index", bus.word_index, 0);
    check("midreset_word_valid", bus.word_valid, 0);
    check("midreset_frame_done", bus.frame_done, 0);
    check("midreset_frame_error", bus.frame_error, 0);
    check("midreset_busy", bus.busy, 0);
    send_random_bits(40);
    check("idle_edges_busy", bus.busy, 0);
    drain();

    // Full frame, word k = 0xA5A50000 + k, 4 high / 4 low
    do_start(1);
    for (int k = 0; k < WORDS; k++) send_word(32'hA5A50000 + 32'(k), 4, 4);
    drain();
    check("full_frame_last_data", bus.word_data, 32'hA5A5000D);
    check("full_frame_last_index", bus.word_index, 13);
    check("full_frame_busy_dropped", bus.busy, 0);
    check("full_frame_no_error", bus.frame_error, 0);

    // Timeout: 20 bits then silence
    do_start(1);
    for (int i = 0; i < 19; i++) send_bit(1'($urandom), 4, 4);
    bus.data_clk = 1'b0;
    bus.data_in  = 1'b1;
    repeat (4) @(negedge CLK);
    bus.data_clk = 1'b1;
    c_last = cyc;
    model_edge(1'b1, cyc);
    repeat (4) @(negedge CLK);
    bus.data_clk = 1'b0;
    while (cyc < c_last + 3 + TIMEOUT - 1) @(negedge CLK);
    check("timeout_error_not_early", bus.frame_error, 0);
    check("timeout_busy_not_early", bus.busy, 1);
    @(negedge CLK);
    check("timeout_error_set", bus.frame_error, 1);
    check("timeout_busy_dropped", bus.busy, 0);
    in_frame = 0;
    drain();

    // Restart: start, 50 bits, start again, then all-ones frame
    do_start(1);
    send_random_bits(50);
    do_start(0);
    for (int k = 0; k < WORDS; k++) send_word(32'hFFFFFFFF, 4, 4);
    drain();
    check("restart_last_data", bus.word_data, 32'hFFFFFFFF);
    check("restart_busy_dropped", bus.busy, 0);

    // Minimum timing, alternating patterns
    do_start(1);
    for (int k = 0; k < WORDS; k++) send_word((k % 2 == 0) ? 32'h55555555 : 32'hAAAAAAAA, 3, 3);
    drain();
    check("min_timing_last_data", bus.word_data, 32'hAAAAAAAA);

    // Randomized frames with random bit timing and optional restarts
    for (int r = 0; r < 3; r++) begin
      do_start(1);
      if ($urandom_range(0, 1) == 1) begin
        pre = $urandom_range(1, 100);
        send_random_bits(pre);
        do_start(0);
      end
      for (int k = 0; k < WORDS; k++) begin
        w = $urandom;
        for (int i = WORD_W - 1; i >= 0; i--) begin
          hi = $urandom_range(3, 6);
          lo = $urandom_range(3, 6);
          send_bit(w[i], hi, lo);
        end
      end
      drain();
      check("random_frame_busy_dropped", bus.busy, 0);
      check("random_frame_no_error", bus.frame_error, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_serial_rx.md
# dff_serial_rx

Deserializing receiver for the DFF error-count readout stream: the capture end of the serial link that shifts the 14 latched 32-bit DFF error counters out on a slow, externally driven data clock. It synchronizes the externally clocked shift clock and data line into the system clock domain, reassembles 32-bit words, and reports per-word and per-frame completion, with a timeout to recover from a stalled stream. It is used for loopback self-test of the readout chain on the FPGA, and as the reference capture model in the readout testbench.

## Interface
Parameters:
- WORDS, 14, words per frame (one per DFF error counter)
- WORD_W, 32, bits per word
- TIMEOUT, 50000, CLK cycles without a data_clk rising edge before an in-progress frame is aborted

Ports:
- CLK  in  1  system clock; one clock only
- reset  in  1  synchronous, active-high reset
- data_clk  in  1  serial shift clock, asynchronous to CLK
- data_in  in  1  serial data, asynchronous to CLK, valid around data_clk rising edge
- start  in  1  frame start request, asynchronous, acts on its rising edge
- word_data  out  WORD_W  last completed word
- word_index  out  4  index of word_data, 0..WORDS-1
- word_valid  out  1  one-cycle pulse when word_data/word_index update
- frame_done  out  1  one-cycle pulse after the last word of a frame
- frame_error  out  1  sticky; set on timeout
- busy  out  1  high while in RECV

## Operation
- Synchronizers: data_clk, data_in and start each pass through a 2-FF synchronizer, then one more register for edge detection. An edge is `s2 & ~s3`. Shifted data is the synchronized data_in (s2) in the edge cycle.
- Bit order: word 0 first; within a word, MSB first.
- States: IDLE, RECV.
- IDLE:
  - data_clk edges are ignored.
  - A start edge clears the bit counter, word counter, timeout counter and frame_error, then enters RECV.
- RECV, on each data_clk edge:
  - Shift the bit into the shift register, increment the bit counter (0..WORD_W-1), and clear the timeout counter.
- Word completion (edge with bit counter = WORD_W-1):
  - Next cycle: word_data <= assembled word, word_index <= word counter, word_valid = 1.
  - Bit counter wraps to 0.
  - If word counter = WORDS-1: frame_done pulses in the same cycle as word_valid and the state returns to IDLE. Otherwise the word counter increments.
- Timeout: in RECV with no edge, the timeout counter increments. When it reaches TIMEOUT-1, frame_error is set, the state goes to IDLE, and the partial word is discarded (no word_valid).
- A start edge during RECV restarts the frame: counters clear, the partial word is discarded, frame_error clears, and the state stays in RECV.
- A start edge in the same cycle as a data_clk edge: start wins and the bit is dropped.
- A start edge in the same cycle as a timeout: start wins; frame_error stays 0.
- reset in any state: all state, counters and outputs return to reset values next cycle.
- Widths: bit counter 5 bits, word counter 4 bits, timeout counter 16 bits; no counter saturates past its stated wrap.

## Timing
- Reset values: word_data=0, word_index=0, word_valid=0, frame_done=0, frame_error=0, busy=0, state IDLE, all synchronizer registers 0.
- Latency: a data_clk rising edge at the pin is seen as an edge 3 CLK later (2 sync + 1 detect). The shift register updates on that edge. word_valid for the 32nd bit asserts 4 CLK after the pin edge.
- start edge to busy=1: 4 CLK.
- Input constraints:
  - data_clk high ≥3 CLK and low ≥3 CLK.
  - data_in stable from 3 CLK before to 3 CLK after each data_clk rising edge.
  - Violations give undefined data but never a hang; the timeout still recovers.
- word_data/word_index hold between word_valid pulses. word_valid and frame_done are never high for 2 consecutive cycles.
- Throughput: at most 1 bit per 6 CLK.

## Test plan
- Reset: assert reset 2 cycles mid-frame -> all outputs 0, busy=0; subsequent data_clk edges produce no word_valid.
- Full frame: start, then 448 bits with word k = 0xA5A50000+k, data_clk 4 high/4 low CLK -> 14 word_valid pulses, index 0..13, data matching, frame_done with index 13, busy drops, frame_error=0.
- Idle edges: 40 data_clk edges without start -> no word_valid, busy=0; then a normal frame decodes correctly.
- Timeout: start, 20 bits, stop data_clk -> frame_error=1 and busy=0 exactly TIMEOUT cycles after the last detected edge; no word_valid. The next start clears frame_error.
- Restart: start, 50 bits, start again, then a full frame of 0xFFFFFFFF words -> word 0 is 0xFFFFFFFF (no stale bits), 14 words and frame_done.
- Minimum timing: data_clk 3 high/3 low with alternating 0x55555555/0xAAAAAAAA words -> all 14 captured correctly.
